// File: rtl/mem_bus_arbiter.sv
// Two-host round-robin arbiter in front of one req/gnt + in-order rvalid memory port.
// Latency: request and response paths are combinational (0 cycles); state updates on the next edge.
// Backpressure: dev_gnt=0 or a full ID FIFO holds the winner off; hosts keep req stable until gnt.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         h0_req,
  input  logic                         h0_we,
  input  logic [AW-1:0]                h0_addr,
  input  logic [DW-1:0]                h0_wdata,
  input  logic [DW/8-1:0]              h0_wmask,
  output logic                         h0_gnt,
  output logic                         h0_rvalid,
  output logic [DW-1:0]                h0_rdata,
  output logic [1:0]                   h0_error,
  input  logic                         h1_req,
  input  logic                         h1_we,
  input  logic [AW-1:0]                h1_addr,
  input  logic [DW-1:0]                h1_wdata,
  input  logic [DW/8-1:0]              h1_wmask,
  output logic                         h1_gnt,
  output logic                         h1_rvalid,
  output logic [DW-1:0]                h1_rdata,
  output logic [1:0]                   h1_error,
  output logic                         dev_req,
  output logic                         dev_we,
  output logic [AW-1:0]                dev_addr,
  output logic [DW-1:0]                dev_wdata,
  output logic [DW/8-1:0]              dev_wmask,
  input  logic                         dev_gnt,
  input  logic                         dev_rvalid,
  input  logic [DW-1:0]                dev_rdata,
  input  logic [1:0]                   dev_error,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o,
  output logic                         resp_err_o
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = $clog2(MAX_OUT);

  logic          last_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic          id_mem [MAX_OUT];
  logic          resp_err_q;

  logic winner;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head_id;

  // Winner: a lone requester wins; on a tie the host that did not win last time goes.
  always_comb begin
    winner = 1'b0;
    if (h0_req && h1_req) begin
      winner = ~last_q;
    end else if (h1_req) begin
      winner = 1'b1;
    end
  end

  // Full uses the registered count, so a same-cycle pop never unblocks a push.
  assign full    = (count_q == CW'(MAX_OUT));
  assign empty   = (count_q == '0);
  assign dev_req = (h0_req | h1_req) & ~full & ~rst_i;
  assign push    = dev_req & dev_gnt;
  assign pop     = dev_rvalid & ~empty & ~rst_i;
  assign head_id = id_mem[rd_ptr_q];

  assign dev_we    = winner ? h1_we    : h0_we;
  assign dev_addr  = winner ? h1_addr  : h0_addr;
  assign dev_wdata = winner ? h1_wdata : h0_wdata;
  assign dev_wmask = winner ? h1_wmask : h0_wmask;

  assign h0_gnt = push & ~winner;
  assign h1_gnt = push &  winner;

  assign h0_rvalid = pop & ~head_id;
  assign h1_rvalid = pop &  head_id;
  assign h0_rdata  = dev_rdata;
  assign h1_rdata  = dev_rdata;
  assign h0_error  = dev_error;
  assign h1_error  = dev_error;

  assign outstanding_o = count_q;
  assign resp_err_o    = resp_err_q;

  // ID storage: slot contents need no reset, validity is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem[wr_ptr_q] <= winner;
    end
  end

  // Pointers, occupancy, round-robin history and the sticky unexpected-response flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q     <= 1'b1;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        last_q   <= winner;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      if (dev_rvalid && empty) begin
        resp_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic.
// Expected values come from a queue-based model of outstanding host IDs.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_OUT = 4;
  localparam int CW = $clog2(MAX_OUT + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic h0_req = 0, h0_we = 0, h1_req = 0, h1_we = 0;
  logic [AW-1:0] h0_addr = '0, h1_addr = '0;
  logic [DW-1:0] h0_wdata = '0, h1_wdata = '0;
  logic [DW/8-1:0] h0_wmask = '0, h1_wmask = '0;
  logic h0_gnt, h0_rvalid, h1_gnt, h1_rvalid;
  logic [DW-1:0] h0_rdata, h1_rdata;
  logic [1:0] h0_error, h1_error;
  logic dev_req, dev_we;
  logic [AW-1:0] dev_addr;
  logic [DW-1:0] dev_wdata;
  logic [DW/8-1:0] dev_wmask;
  logic dev_gnt = 0, dev_rvalid = 0;
  logic [DW-1:0] dev_rdata = '0;
  logic [1:0] dev_error = '0;
  logic [CW-1:0] outstanding;
  logic resp_err;

  int checks = 0;
  int failures = 0;

  // Model: queue of host IDs awaiting a response, last winner, sticky error.
  bit id_q[$];
  bit m_last = 1'b1;
  bit m_err = 1'b0;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .h0_req(h0_req), .h0_we(h0_we), .h0_addr(h0_addr), .h0_wdata(h0_wdata), .h0_wmask(h0_wmask),
    .h0_gnt(h0_gnt), .h0_rvalid(h0_rvalid), .h0_rdata(h0_rdata), .h0_error(h0_error),
    .h1_req(h1_req), .h1_we(h1_we), .h1_addr(h1_addr), .h1_wdata(h1_wdata), .h1_wmask(h1_wmask),
    .h1_gnt(h1_gnt), .h1_rvalid(h1_rvalid), .h1_rdata(h1_rdata), .h1_error(h1_error),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_wmask(dev_wmask), .dev_gnt(dev_gnt), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata),
    .dev_error(dev_error), .outstanding_o(outstanding), .resp_err_o(resp_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_winner(bit a, bit b);
    if (a && !b) return 1'b0;
    if (b && !a) return 1'b1;
    return !m_last;
  endfunction

  function automatic bit m_devreq();
    return (h0_req || h1_req) && (id_q.size() < MAX_OUT);
  endfunction

  // Advance the model by the handshake happening in the current cycle.
  task automatic m_commit();
    bit push, pop, w;
    push = m_devreq() && dev_gnt;
    pop  = dev_rvalid && (id_q.size() > 0);
    w    = m_winner(h0_req, h1_req);
    if (dev_rvalid && id_q.size() == 0) m_err = 1'b1;
    if (pop) void'(id_q.pop_front());
    if (push) begin
      id_q.push_back(w);
      m_last = w;
    end
  endtask

  task automatic apply(input bit a, input bit b, input bit g, input bit rv);
    @(posedge clk);
    #1;
    h0_req = a; h1_req = b; dev_gnt = g; dev_rvalid = rv; dev_error = 2'b00;
  endtask

  task automatic test_reset();
    h0_req = 1; h1_req = 1; dev_gnt = 1; dev_rvalid = 1;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (dev_req !== 1'b0) begin failures++; $display("FAIL rst_dev_req got=%b exp=0", dev_req); end
    checks++; if ({h0_gnt, h1_gnt} !== 2'b00) begin failures++; $display("FAIL rst_gnt got=%b exp=00", {h0_gnt, h1_gnt}); end
    checks++; if ({h0_rvalid, h1_rvalid} !== 2'b00) begin failures++; $display("FAIL rst_rvalid got=%b exp=00", {h0_rvalid, h1_rvalid}); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
    h0_req = 0; h1_req = 0; dev_gnt = 0; dev_rvalid = 0;
    @(negedge clk);
    rst = 0;
    apply(0, 0, 0, 0);
    #1;
    checks++; if (outstanding !== '0) begin failures++; $display("FAIL rst_count got=%0d exp=0", outstanding); end
    m_commit();
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a0;
    h1_addr = 32'hCAFE_0010; h1_we = 1; h1_wdata = 32'h1234_5678; h1_wmask = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 0, 0);
      #1;
      if (i == 0) a0 = dev_addr;
      checks++; if (h1_gnt !== 1'b0) begin failures++; $display("FAIL bp_gnt cyc=%0d got=%b exp=0", i, h1_gnt); end
      checks++; if (dev_req !== 1'b1 || dev_addr !== 32'hCAFE_0010 || dev_addr !== a0 || dev_wdata !== 32'h1234_5678 || dev_wmask !== 4'b1010 || dev_we !== 1'b1)
        begin failures++; $display("FAIL bp_fields cyc=%0d got req=%b addr=%h wd=%h exp addr=cafe0010 wd=12345678", i, dev_req, dev_addr, dev_wdata); end
      m_commit();
    end
    apply(0, 1, 1, 0);
    #1;
    checks++; if (h1_gnt !== 1'b1 || h0_gnt !== 1'b0) begin failures++; $display("FAIL bp_release got h1=%b h0=%b exp h1=1 h0=0", h1_gnt, h0_gnt); end
    m_commit();
    apply(0, 0, 0, 1);
    #1;
    checks++; if (h1_rvalid !== 1'b1 || h0_rvalid !== 1'b0) begin failures++; $display("FAIL bp_resp got h1=%b h0=%b exp h1=1 h0=0", h1_rvalid, h0_rvalid); end
    m_commit();
  endtask

  task automatic test_tie_fairness();
    int n0 = 0, n1 = 0, r0 = 0, r1 = 0;
    logic [AW-1:0] acc_addr = '0;
    bit acc_host = 0;
    h1_we = 0; h0_we = 0;
    for (int i = 0; i < 9; i++) begin
      apply(i < 8, i < 8, 1, i > 0);
      h0_addr = 32'h1000_0000 + 32'(n0 * 4);
      h1_addr = 32'h2000_0000 + 32'(n1 * 4);
      dev_rdata = ~acc_addr;
      #1;
      if (i < 8) begin
        checks++; if (h0_gnt !== (i % 2 == 0) || h1_gnt !== (i % 2 == 1))
          begin failures++; $display("FAIL tie_gnt cyc=%0d got h0=%b h1=%b exp h0=%b", i, h0_gnt, h1_gnt, i % 2 == 0); end
      end
      if (i > 0) begin
        checks++; if (h0_rvalid !== !acc_host || h1_rvalid !== acc_host || (acc_host ? h1_rdata : h0_rdata) !== ~acc_addr)
          begin failures++; $display("FAIL tie_resp cyc=%0d got rv0=%b rv1=%b exp host=%0d", i, h0_rvalid, h1_rvalid, acc_host); end
        r0 += int'(h0_rvalid); r1 += int'(h1_rvalid);
      end
      if (h0_gnt) begin acc_addr = h0_addr; acc_host = 0; n0++; end
      if (h1_gnt) begin acc_addr = h1_addr; acc_host = 1; n1++; end
      m_commit();
    end
    checks++; if (r0 != 4 || r1 != 4 || n0 != 4 || n1 != 4)
      begin failures++; $display("FAIL tie_counts got gnt=%0d/%0d rv=%0d/%0d exp 4/4 4/4", n0, n1, r0, r1); end
  endtask

  task automatic test_full();
    int g = 0;
    for (int i = 0; i < 6; i++) begin
      apply(1, 0, 1, 0);
      #1;
      g += int'(h0_gnt);
      checks++; if (h0_gnt !== (i < 4)) begin failures++; $display("FAIL full_gnt cyc=%0d got=%b exp=%b", i, h0_gnt, i < 4); end
      m_commit();
    end
    apply(1, 0, 1, 1);
    #1;
    checks++; if (outstanding !== 3'd4 || dev_req !== 1'b0 || h0_gnt !== 1'b0 || h0_rvalid !== 1'b1 || g != 4)
      begin failures++; $display("FAIL full_block got cnt=%0d req=%b gnt=%b rv=%b grants=%0d exp 4 0 0 1 4", outstanding, dev_req, h0_gnt, h0_rvalid, g); end
    m_commit();
    apply(1, 0, 1, 0);
    #1;
    checks++; if (outstanding !== 3'd3 || h0_gnt !== 1'b1) begin failures++; $display("FAIL full_unblock got cnt=%0d gnt=%b exp 3 1", outstanding, h0_gnt); end
    m_commit();
    apply(0, 0, 0, 0);
    #1;
    checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL full_refill got=%0d exp=4", outstanding); end
    m_commit();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 1);
      #1;
      checks++; if (h0_rvalid !== 1'b1 || h1_rvalid !== 1'b0) begin failures++; $display("FAIL full_drain cyc=%0d got rv0=%b rv1=%b exp 1 0", i, h0_rvalid, h1_rvalid); end
      m_commit();
    end
  endtask

  task automatic test_interleave();
    bit seq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      apply(!seq[i], seq[i], 1, 0);
      #1;
      if (i == 0) begin
        checks++; if (outstanding !== '0) begin failures++; $display("FAIL il_start_count got=%0d exp=0", outstanding); end
      end
      checks++; if (h0_gnt !== !seq[i] || h1_gnt !== seq[i]) begin failures++; $display("FAIL il_gnt cyc=%0d got h0=%b h1=%b exp host=%0d", i, h0_gnt, h1_gnt, seq[i]); end
      m_commit();
    end
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 1);
      dev_error = (i == 2) ? 2'b01 : 2'b00;
      #1;
      checks++; if (h0_rvalid !== !seq[i] || h1_rvalid !== seq[i]) begin failures++; $display("FAIL il_route cyc=%0d got rv0=%b rv1=%b exp host=%0d", i, h0_rvalid, h1_rvalid, seq[i]); end
      if (i == 2) begin
        checks++; if (h1_error !== 2'b01 || h1_rvalid !== 1'b1) begin failures++; $display("FAIL il_error got err=%b rv1=%b exp 01 1", h1_error, h1_rvalid); end
      end
      m_commit();
    end
  endtask

  task automatic test_unexpected();
    apply(0, 0, 0, 1);
    #1;
    checks++; if (outstanding !== '0 || h0_rvalid !== 1'b0 || h1_rvalid !== 1'b0 || resp_err !== 1'b0)
      begin failures++; $display("FAIL unexp_resp got cnt=%0d rv=%b%b err=%b exp 0 00 0", outstanding, h0_rvalid, h1_rvalid, resp_err); end
    m_commit();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0);
      #1;
      checks++; if (resp_err !== 1'b1 || outstanding !== '0) begin failures++; $display("FAIL unexp_sticky cyc=%0d got err=%b cnt=%0d exp 1 0", i, resp_err, outstanding); end
      m_commit();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 1, 0);
      #1;
      m_commit();
    end
    apply(0, 0, 0, 0);
    #1;
    checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL ar_pre_count got=%0d exp=3", outstanding); end
    m_commit();
    #2;
    h0_req = 1; h1_req = 1; dev_gnt = 1;
    rst = 1;
    #1;
    checks++; if (outstanding !== '0 || h0_gnt !== 1'b0 || h1_gnt !== 1'b0 || dev_req !== 1'b0 || resp_err !== 1'b0)
      begin failures++; $display("FAIL ar_immediate got cnt=%0d gnt=%b%b req=%b err=%b exp 0 00 0 0", outstanding, h0_gnt, h1_gnt, dev_req, resp_err); end
    id_q.delete(); m_last = 1'b1; m_err = 1'b0;
    @(posedge clk);
    #2;
    rst = 0;
    #1;
    checks++; if (h0_gnt !== 1'b1 || h1_gnt !== 1'b0) begin failures++; $display("FAIL ar_first_tie got h0=%b h1=%b exp 1 0", h0_gnt, h1_gnt); end
    m_commit();
    apply(0, 0, 0, 1);
    #1;
    checks++; if (h0_rvalid !== 1'b1) begin failures++; $display("FAIL ar_resp got=%b exp=1", h0_rvalid); end
    m_commit();
    apply(0, 0, 0, 1);
    #1;
    m_commit();
    apply(0, 0, 0, 0);
    #1;
    checks++; if (resp_err !== 1'b1) begin failures++; $display("FAIL ar_late_resp_err got=%b exp=1", resp_err); end
    m_commit();
  endtask

  task automatic test_random();
    bit er, w, pop, hid;
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
            ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      h0_addr = $urandom; h1_addr = $urandom; h0_wdata = $urandom; h1_wdata = $urandom;
      h0_we = 1'($urandom_range(0, 1)); h1_we = 1'($urandom_range(0, 1));
      h0_wmask = 4'($urandom); h1_wmask = 4'($urandom);
      dev_rdata = $urandom; dev_error = 2'($urandom);
      #1;
      er  = m_devreq();
      w   = m_winner(h0_req, h1_req);
      pop = dev_rvalid && id_q.size() > 0;
      hid = pop ? id_q[0] : 1'b0;
      checks++;
      if (dev_req !== er || h0_gnt !== (er && dev_gnt && !w) || h1_gnt !== (er && dev_gnt && w) ||
          h0_rvalid !== (pop && !hid) || h1_rvalid !== (pop && hid) || int'(outstanding) != id_q.size() ||
          resp_err !== m_err || h0_rdata !== dev_rdata || h1_rdata !== dev_rdata || h0_error !== dev_error ||
          (er && (dev_addr !== (w ? h1_addr : h0_addr) || dev_wdata !== (w ? h1_wdata : h0_wdata) ||
                  dev_wmask !== (w ? h1_wmask : h0_wmask) || dev_we !== (w ? h1_we : h0_we)))) begin
        failures++;
        if (bad < 10) $display("FAIL rand cyc=%0d got req=%b gnt=%b%b rv=%b%b cnt=%0d err=%b exp req=%b win=%b pop=%b id=%b cnt=%0d err=%b",
                               i, dev_req, h0_gnt, h1_gnt, h0_rvalid, h1_rvalid, outstanding, resp_err,
                               er, w, pop, hid, id_q.size(), m_err);
        bad++;
      end
      m_commit();
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_tie_fairness();
    test_full();
    test_interleave();
    test_unexpected();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
